// File: rtl/instr_ctrl_pkg.sv
// Shared definitions for the instruction controller: FSM states, opcode fields,
// writeback-select encodings and the bundle of registered control outputs.
package instr_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [3:0] VSEL_NONE   = 4'b0000;
    localparam logic [3:0] VSEL_MDATA  = 4'b1000;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
    localparam logic [3:0] VSEL_PC     = 4'b0010;
    localparam logic [3:0] VSEL_C      = 4'b0001;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
    } ctrl_t;

    // Control word of the idle state: everything off, ready flag set.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c      = '0;
        c.w    = 1'b1;
        c.vsel = VSEL_NONE;
        return c;
    endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational split of the instruction register into its fields plus
// sign extension of the 8-bit and 5-bit immediates.
module instr_dec #(
    parameter int DW = 16
) (
    input  logic [15:0]   ir,
    output logic [DW-1:0] sximm8,
    output logic [DW-1:0] sximm5,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [2:0]    rn,
    output logic [2:0]    rd,
    output logic [1:0]    sh,
    output logic [2:0]    rm
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DW-5){ir[4]}}, ir[4:0]};

endmodule

// File: rtl/instr_ctrl.sv
// Instruction register, decoder and multi-cycle sequencer driving the 16-bit
// datapath controls. Control outputs are registered from the next-state decode.
//
// state    | meaning
// ---------+-----------------------------------------------
// WAIT     | idle, w=1, accepts load_ir and s
// DECODE   | branch on opcode/op of the freshly loaded IR
// GET_A    | read Rn into A
// GET_B    | read Rm into B
// ALU      | compute; CMP updates status, others load C
// WR_REG   | write C back to Rd
// WR_IMM   | write sximm8 to Rn
module instr_ctrl
    import instr_ctrl_pkg::*;
#(
    parameter int          DW       = 16,
    parameter logic [15:0] IR_RESET = 16'h0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   in,
    input  logic          load_ir,
    input  logic          s,
    output logic          w,
    output logic [DW-1:0] sximm8,
    output logic [DW-1:0] sximm5,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [3:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop
);

    logic [15:0] ir;
    state_t      state;
    state_t      next_state;
    ctrl_t       ctrl;
    ctrl_t       next_ctrl;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;

    instr_dec #(.DW(DW)) u_dec (
        .ir     (ir),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm)
    );

    assign shift = sh;

    always_comb begin
        next_state = S_WAIT;
        case (state)
            S_WAIT:   next_state = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (opcode == OPC_MOV && op == OP_MOV_IMM)
                    next_state = S_WR_IMM;
                else if ((opcode == OPC_MOV && op == OP_MOV_REG) ||
                         (opcode == OPC_ALU && op == OP_MVN))
                    next_state = S_GET_B;
                else if (opcode == OPC_ALU)
                    next_state = S_GET_A;
                else
                    next_state = S_WAIT;
            end
            S_GET_A:  next_state = S_GET_B;
            S_GET_B:  next_state = S_ALU;
            S_ALU:    next_state = (opcode == OPC_ALU && op == OP_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: next_state = S_WAIT;
            S_WR_IMM: next_state = S_WAIT;
            default:  next_state = S_WAIT;
        endcase
    end

    // IR is stable from DECODE onward, so decoding it against next_state is safe.
    always_comb begin
        next_ctrl = '0;
        case (next_state)
            S_WAIT:  next_ctrl.w = 1'b1;
            S_GET_A: begin
                next_ctrl.readnum = rn;
                next_ctrl.loada   = 1'b1;
            end
            S_GET_B: begin
                next_ctrl.readnum = rm;
                next_ctrl.loadb   = 1'b1;
            end
            S_ALU: begin
                next_ctrl.aluop = (opcode == OPC_MOV) ? 2'b00 : op;
                next_ctrl.asel  = (opcode == OPC_MOV) || (op == OP_MVN);
                next_ctrl.bsel  = 1'b0;
                if (opcode == OPC_ALU && op == OP_CMP)
                    next_ctrl.loads = 1'b1;
                else
                    next_ctrl.loadc = 1'b1;
            end
            S_WR_REG: begin
                next_ctrl.writenum = rd;
                next_ctrl.vsel     = VSEL_C;
                next_ctrl.write    = 1'b1;
            end
            S_WR_IMM: begin
                next_ctrl.writenum = rn;
                next_ctrl.vsel     = VSEL_SXIMM8;
                next_ctrl.write    = 1'b1;
            end
            default: next_ctrl = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= IR_RESET;
            ctrl  <= ctrl_idle();
        end else begin
            state <= next_state;
            ctrl  <= next_ctrl;
            if (load_ir && state == S_WAIT)
                ir <= in;
        end
    end

    assign w        = ctrl.w;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign write    = ctrl.write;
    assign vsel     = ctrl.vsel;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign asel     = ctrl.asel;
    assign bsel     = ctrl.bsel;
    assign ALUop    = ctrl.aluop;

endmodule

// File: tb/tb_instr_ctrl.sv
// Bench for instr_ctrl: a vector table of instructions with their expected
// control sequence summaries, checked through a scoreboard queue, plus reset,
// busy-guard and continuous-start sequences.
module tb_instr_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in;
    logic        load_ir;
    logic        s;
    logic        w;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_ctrl #(.DW(16), .IR_RESET(16'h0)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in),
        .load_ir  (load_ir),
        .s        (s),
        .w        (w),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop)
    );

    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          n_la;
        int          ra;
        int          n_lb;
        int          rb;
        int          n_alu;
        int          aluop;
        int          asel;
        int          loadc;
        int          loads;
        int          n_wr;
        int          wnum;
        int          vsel;
        logic [15:0] sx8;
        logic [15:0] sx5;
        int          shift;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one instruction, observes its whole run, then compares against the
    // scoreboard entry. poke_cyc>0 raises load_ir with a different word mid-run.
    task automatic run_instr(input vec_t v, input int poke_cyc, input string tag);
        vec_t e;
        int cyc, n_la, ra, n_lb, rb, n_alu, o_aluop, o_asel, o_bsel, o_loadc, o_loads;
        int n_wr, wnum, o_vsel, lat;
        bit done;
        n_la = 0; ra = 0; n_lb = 0; rb = 0; n_alu = 0; o_aluop = 0; o_asel = 0;
        o_bsel = 0; o_loadc = 0; o_loads = 0; n_wr = 0; wnum = 0; o_vsel = 0; lat = -1;
        sb.push_back(v);
        @(negedge clk);
        in = v.instr; load_ir = 1'b1; s = 1'b1;
        @(posedge clk);
        cyc  = 1;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (cyc == 1) begin load_ir = 1'b0; s = 1'b0; end
            if (poke_cyc != 0 && cyc == poke_cyc) begin in = 16'hD0FD; load_ir = 1'b1; end
            else if (poke_cyc != 0 && cyc == poke_cyc + 1) load_ir = 1'b0;
            if (loada) begin n_la++; ra = int'(readnum); end
            if (loadb) begin n_lb++; rb = int'(readnum); end
            if (loadc || loads) begin
                n_alu++; o_aluop = int'(ALUop); o_asel = int'(asel); o_bsel = int'(bsel);
                o_loadc = int'(loadc); o_loads = int'(loads);
            end
            if (write) begin n_wr++; wnum = int'(writenum); o_vsel = int'(vsel); end
            if (w) begin
                lat = cyc; done = 1'b1;
            end else if (cyc >= 20) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
        load_ir = 1'b0;
        e = sb.pop_front();
        check({tag, " latency"},  lat,     e.lat);
        check({tag, " n_loada"},  n_la,    e.n_la);
        check({tag, " ra"},       ra,      e.ra);
        check({tag, " n_loadb"},  n_lb,    e.n_lb);
        check({tag, " rb"},       rb,      e.rb);
        check({tag, " n_alu"},    n_alu,   e.n_alu);
        check({tag, " aluop"},    o_aluop, e.aluop);
        check({tag, " asel"},     o_asel,  e.asel);
        check({tag, " bsel"},     o_bsel,  0);
        check({tag, " loadc"},    o_loadc, e.loadc);
        check({tag, " loads"},    o_loads, e.loads);
        check({tag, " n_write"},  n_wr,    e.n_wr);
        check({tag, " writenum"}, wnum,    e.wnum);
        check({tag, " vsel"},     o_vsel,  e.vsel);
        check({tag, " sximm8"},   int'(sximm8), int'(e.sx8));
        check({tag, " sximm5"},   int'(sximm5), int'(e.sx5));
        check({tag, " shift"},    int'(shift),  e.shift);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_w[7];
        bit exp_wr[7];
        int cyc;
        //          instr    lat la ra lb rb alu op as lc ls wr wn vs sx8       sx5       sh
        vecs[0] = '{16'hD0FD, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 16'hFFFD, 16'hFFFD, 3};
        vecs[1] = '{16'hA148, 6, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 2, 1, 16'h0048, 16'h0008, 1};
        vecs[2] = '{16'hA900, 5, 1, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[3] = '{16'hB864, 5, 0, 0, 1, 4, 1, 3, 1, 1, 0, 1, 3, 1, 16'h0064, 16'h0004, 0};
        vecs[4] = '{16'hB6A7, 6, 1, 6, 1, 7, 1, 2, 0, 1, 0, 1, 5, 1, 16'hFFA7, 16'h0007, 0};
        vecs[5] = '{16'hC032, 5, 0, 0, 1, 2, 1, 0, 1, 1, 0, 1, 1, 1, 16'h0032, 16'hFFF2, 2};
        vecs[6] = '{16'h0123, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0023, 16'h0003, 0};
        vecs[7] = '{16'hD880, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFF80, 16'h0000, 0};
        vecs[8] = '{16'hD77F, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 4, 16'h007F, 16'hFFFF, 3};

        reset_n = 1'b0; in = 16'h0; load_ir = 1'b0; s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset w",      int'(w),      1);
        check("reset write",  int'(write),  0);
        check("reset loads",  int'({loada, loadb, loadc, loads}), 0);
        check("reset vsel",   int'(vsel),   0);
        check("reset sximm8", int'(sximm8), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle w", int'(w), 1);

        foreach (vecs[i]) run_instr(vecs[i], 0, $sformatf("vec%0d", i));

        // load_ir during GET_B of ADD must not disturb IR
        run_instr(vecs[1], 3, "busy_guard");

        // s held high: MOV imm re-executes after exactly one WAIT cycle
        exp_w  = '{0, 0, 1, 0, 0, 1, 0};
        exp_wr = '{0, 1, 0, 0, 1, 0, 0};
        @(negedge clk);
        in = 16'hD0FD; load_ir = 1'b1; s = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            load_ir = 1'b0;
            check($sformatf("s_held w e%0d", k + 1),     int'(w),     int'(exp_w[k]));
            check($sformatf("s_held write e%0d", k + 1), int'(write), int'(exp_wr[k]));
        end
        s = 1'b0;
        cyc = 0;
        while (!w && cyc < 10) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("s_held drain cycles", cyc, 2);

        // reset asserted in the ALU state of ADD
        @(negedge clk);
        in = 16'hA148; load_ir = 1'b1; s = 1'b1;
        @(posedge clk);
        #1 load_ir = 1'b0; s = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset loadc", int'(loadc), 1);
        reset_n = 1'b0;
        #1;
        check("mid_reset w",      int'(w),      1);
        check("mid_reset loadc",  int'(loadc),  0);
        check("mid_reset write",  int'(write),  0);
        check("mid_reset vsel",   int'(vsel),   0);
        check("mid_reset sximm8", int'(sximm8), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("in_reset write c%0d", k), int'(write), 0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_reset write c%0d", k), int'(write), 0);
            check($sformatf("post_reset w c%0d", k),     int'(w),     1);
        end

        check("scoreboard empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
